usr_seq_ctrl: RTL and testbench

Command sequencer for the team's universal_shift_register.
- Accepts one command at a time over a valid/ready handshake: load, shift-right-N, shift-left-N, or load-then-shift-right-N.
- Drives the register's sel/parin inputs cycle by cycle.
- Captures the register output when the command finishes and pulses done.
- Sits between a host/bus-side requester and a single universal_shift_register instance.

---
 rtl/usr_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_usr_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq_ctrl.sv
// Command sequencer driving a universal_shift_register: load / shift-right-N / shift-left-N / load-then-shift-right-N.
// Optional build macro USR_CTRL_CNT_CLAMP_EN clamps the latched shift count to WIDTH.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_sel,
  output logic [WIDTH-1:0] usr_parin,
  input  logic [WIDTH-1:0] usr_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

`ifdef USR_CTRL_CNT_CLAMP_EN
  // If WIDTH exceeds the largest representable count the clamp never engages.
  localparam int               CNT_MAX   = (1 << CNT_W) - 1;
  localparam int               CLAMP_INT = (WIDTH < CNT_MAX) ? WIDTH : CNT_MAX;
  localparam logic [CNT_W-1:0] CLAMP_CNT = CLAMP_INT[CNT_W-1:0];
  assign cnt_next = (cmd_cnt > CLAMP_CNT) ? CLAMP_CNT : cmd_cnt;
`else
  assign cnt_next = cmd_cnt;
`endif

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);

  function automatic logic [1:0] shift_sel(input logic [1:0] op);
    return (op == OP_SHL) ? SEL_SHL : SEL_SHR;
  endfunction

  // usr_sel is loaded on the edge that enters a state, so it is valid for that whole state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= S_IDLE;
      op_reg    <= OP_LOAD;
      cnt_reg   <= '0;
      usr_sel   <= SEL_HOLD;
      usr_parin <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          usr_sel <= SEL_HOLD;
          if (cmd_valid) begin
            op_reg  <= cmd_op;
            cnt_reg <= cnt_next;
            if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
              state_reg <= S_LOAD;
              usr_sel   <= SEL_LOAD;
              usr_parin <= cmd_data;
            end else if (cnt_next != '0) begin
              state_reg <= S_SHIFT;
              usr_sel   <= shift_sel(cmd_op);
            end else begin
              state_reg <= S_CAPTURE;
            end
          end
        end
        S_LOAD: begin
          if (op_reg == OP_LOAD_SHR && cnt_reg != '0) begin
            state_reg <= S_SHIFT;
            usr_sel   <= SEL_SHR;
          end else begin
            state_reg <= S_CAPTURE;
            usr_sel   <= SEL_HOLD;
          end
        end
        S_SHIFT: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= S_CAPTURE;
            usr_sel   <= SEL_HOLD;
          end
        end
        S_CAPTURE: begin
          result    <= usr_out;
          done      <= 1'b1;
          state_reg <= S_DONE;
          usr_sel   <= SEL_HOLD;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          usr_sel   <= SEL_HOLD;
        end
        default: begin
          state_reg <= S_IDLE;
          usr_sel   <= SEL_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: vector table plus scoreboard, zero-fill shift register model on usr_sel/usr_parin.
// Honours USR_CTRL_CNT_CLAMP_EN when computing expected shift counts.
module tb_usr_seq_ctrl;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [1:0] usr_sel;
  logic [3:0] usr_parin;
  logic [3:0] usr_out;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] reg_model = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [3:0] data;
    logic [3:0] res;
    logic [3:0] parin;
    int         lat;
    int         nld;
    int         nshr;
    int         nshl;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    int         lat;
  } exp_t;

  vec_t vecs[15];
  exp_t sb_q[$];

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .usr_sel(usr_sel), .usr_parin(usr_parin), .usr_out(usr_out),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // External universal shift register, zero fill; it has no reset of its own.
  always @(posedge clk) begin
    case (usr_sel)
      2'b01:   reg_model <= {1'b0, reg_model[3:1]};
      2'b10:   reg_model <= {reg_model[2:0], 1'b0};
      2'b11:   reg_model <= usr_parin;
      default: reg_model <= reg_model;
    endcase
  end
  assign usr_out = reg_model;

  function automatic int eff(input int c);
`ifdef USR_CTRL_CNT_CLAMP_EN
    return (c > 4) ? 4 : c;
`else
    return c;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic pop_check(input string tag, input int lat);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, " sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " result"}, int'(result), int'(e.res));
      chk({tag, " latency"}, lat, e.lat);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    nld = 0, nshr = 0, nshl = 0, ready_hi = 0, lat = 0;
    exp_t  e;
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_ready();
    cmd_op = v.op; cmd_cnt = v.cnt; cmd_data = v.data; cmd_valid = 1'b1;
    e.res = v.res; e.lat = v.lat;
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      case (usr_sel)
        2'b11:   nld++;
        2'b01:   nshr++;
        2'b10:   nshl++;
        default: ;
      endcase
      if (cmd_ready) ready_hi++;
      if (done) begin
        lat = c;
        break;
      end
    end
    pop_check(tag, lat);
    chk({tag, " parin"}, int'(usr_parin), int'(v.parin));
    chk({tag, " n_load"}, nld, v.nld);
    chk({tag, " n_shr"}, nshr, v.nshr);
    chk({tag, " n_shl"}, nshl, v.nshl);
    chk({tag, " ready_while_busy"}, ready_hi, 0);
    $display("vec %0d op=%b cnt=%0d data=%b -> result=%b lat=%0d", idx, v.op, v.cnt, v.data, result, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_seq[9];
    int         done1, done2, ready_early, ready6;
    int         dpulse, sel_nz;

    //          op           cnt   data     res      parin    lat           nld nshr     nshl
    vecs[0]  = '{OP_LOAD,     3'd5, 4'b1011, 4'b1011, 4'b1011, 3,           1,  0,       0};
    vecs[1]  = '{OP_LOAD_SHR, 3'd2, 4'b1011, 4'b0010, 4'b1011, 5,           1,  2,       0};
    vecs[2]  = '{OP_LOAD,     3'd0, 4'b1011, 4'b1011, 4'b1011, 3,           1,  0,       0};
    vecs[3]  = '{OP_SHL,      3'd0, 4'b0000, 4'b1011, 4'b1011, 2,           0,  0,       0};
    vecs[4]  = '{OP_SHL,      3'd1, 4'b0000, 4'b0110, 4'b1011, 3,           0,  0,       1};
    vecs[5]  = '{OP_SHR,      3'd0, 4'b0101, 4'b0110, 4'b1011, 2,           0,  0,       0};
    vecs[6]  = '{OP_LOAD,     3'd0, 4'b0001, 4'b0001, 4'b0001, 3,           1,  0,       0};
    vecs[7]  = '{OP_SHL,      3'd3, 4'b0000, 4'b1000, 4'b0001, 5,           0,  0,       3};
    vecs[8]  = '{OP_LOAD_SHR, 3'd0, 4'b1111, 4'b1111, 4'b1111, 3,           1,  0,       0};
    vecs[9]  = '{OP_SHR,      3'd7, 4'b0000, 4'b0000, 4'b1111, eff(7) + 2,  0,  eff(7),  0};
    vecs[10] = '{OP_LOAD,     3'd7, 4'b1100, 4'b1100, 4'b1100, 3,           1,  0,       0};
    vecs[11] = '{OP_SHR,      3'd5, 4'b0000, 4'b0000, 4'b1100, eff(5) + 2,  0,  eff(5),  0};
    vecs[12] = '{OP_LOAD_SHR, 3'd1, 4'b1101, 4'b0110, 4'b1101, 4,           1,  1,       0};
    vecs[13] = '{OP_SHL,      3'd2, 4'b0000, 4'b1000, 4'b1101, 4,           0,  0,       2};
    vecs[14] = '{OP_LOAD_SHR, 3'd3, 4'b1000, 4'b0001, 4'b1000, 6,           1,  3,       0};

    // Reset state after clocking under reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst usr_sel", int'(usr_sel), 0);
    chk("rst parin", int'(usr_parin), 0);
    chk("rst result", int'(result), 0);
    chk("rst done", int'(done), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst ready", int'(cmd_ready), 1);
    clr = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Requester holds cmd_valid across a busy SHL 3; SHR 1 must wait until IDLE.
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    vecs[0] = '{OP_LOAD, 3'd0, 4'b0001, 4'b0001, 4'b0001, 3, 1, 0, 0};
    run_vec(100, vecs[0]);
    wait_ready();
    cmd_op = OP_SHL; cmd_cnt = 3'd3; cmd_data = 4'b0000; cmd_valid = 1'b1;
    sb_q.push_back('{4'b1000, 5});
    sb_q.push_back('{4'b0100, 9});
    done1 = 0; done2 = 0; ready_early = 0; ready6 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cmd_op = OP_SHR; cmd_cnt = 3'd1;
      end
      if (c <= 9) chk($sformatf("b2b sel c%0d", c), int'(usr_sel), int'(exp_seq[c-1]));
      if (c <= 5 && cmd_ready) ready_early++;
      if (c == 6) ready6 = int'(cmd_ready);
      if (c > 6 && busy) cmd_valid = 1'b0;
      if (done) begin
        if (done1 == 0) begin
          done1 = c;
          pop_check("b2b first", c);
        end else if (done2 == 0) begin
          done2 = c;
          pop_check("b2b second", c);
        end
      end
    end
    cmd_valid = 1'b0;
    chk("b2b ready_while_busy", ready_early, 0);
    chk("b2b ready_in_idle", ready6, 1);
    chk("b2b second_done_seen", (done2 != 0) ? 1 : 0, 1);
    while (sb_q.size() > 0) void'(sb_q.pop_front());
    $display("b2b SHL3+SHR1 done at cycles %0d and %0d", done1, done2);

    // Asynchronous reset mid-SHIFT of SHR 7: immediate IDLE, no done afterwards.
    vecs[0] = '{OP_LOAD, 3'd0, 4'b1011, 4'b1011, 4'b1011, 3, 1, 0, 0};
    run_vec(101, vecs[0]);
    wait_ready();
    cmd_op = OP_SHR; cmd_cnt = 3'd7; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort in_shift sel", int'(usr_sel), 1);
    #2 clr = 1'b1;
    #1;
    chk("abort usr_sel", int'(usr_sel), 0);
    chk("abort result", int'(result), 0);
    chk("abort done", int'(done), 0);
    chk("abort ready", int'(cmd_ready), 1);
    chk("abort busy", int'(busy), 0);
    chk("abort parin", int'(usr_parin), 0);
    @(negedge clk);
    clr = 1'b0;
    dpulse = 0; sel_nz = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dpulse++;
      if (usr_sel != 2'b00) sel_nz++;
    end
    chk("abort no_done", dpulse, 0);
    chk("abort sel_idle", sel_nz, 0);
    $display("abort SHR7 by clr: done pulses=%0d result=%b", dpulse, result);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
